// File: rtl/breakpoint_unit_if.sv
// Breakpoint table write port shared between the debug host (master) and breakpoint_unit (slave).
interface breakpoint_unit_if;
    localparam int unsigned AddrW = 16;
    localparam int unsigned IdxW  = 2;

    logic             i_bpWrite;
    logic [IdxW-1:0]  i_bpIndex;
    logic [AddrW-1:0] i_bpAddr;
    logic             i_bpValid;

    modport master (output i_bpWrite, output i_bpIndex, output i_bpAddr, output i_bpValid);
    modport slave  (input  i_bpWrite, input  i_bpIndex, input  i_bpAddr, input  i_bpValid);
endinterface

// File: rtl/breakpoint_unit.sv
// Four-entry PC breakpoint unit: halts the CPU at instruction boundaries whose next PC hits a valid entry.
// Optional hit counter is enabled with `define BREAKPOINT_COUNT_EN.
module breakpoint_unit (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_breakpointEnableN,
    input  logic                i_halt,
    input  logic                i_ctrlInstrFinishedN,
    input  logic [15:0]         i_pc,
    input  logic                i_continue,
    breakpoint_unit_if.slave    bpBus,
    output logic                o_breakpointHitN,
    output logic [1:0]          o_hitIndex
`ifdef BREAKPOINT_COUNT_EN
    ,
    output logic [7:0]          o_hitCount
`endif
);
    localparam int unsigned NumEntries = 4;
    localparam int unsigned AddrW      = 16;
    localparam int unsigned IdxW       = 2;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        RUN      = 2'd1,
        HIT      = 2'd2
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [AddrW-1:0]       bpAddr [NumEntries];
    logic [NumEntries-1:0]  bpValid;
    logic                   boundary;
    logic                   match;
    logic [IdxW-1:0]        matchIdx;
    logic                   hitLoad;

    // Compare against the registered table, so a same-cycle write is not yet visible.
    always_comb begin
        boundary = !i_ctrlInstrFinishedN && i_halt;
        match    = 1'b0;
        matchIdx = '0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (bpValid[i] && (bpAddr[i] == i_pc)) begin
                match    = 1'b1;
                matchIdx = IdxW'(i);
            end
        end
        match = match && boundary && !i_breakpointEnableN;
    end

    // Next-state logic; disable overrides everything, and a match beats any HIT exit.
    always_comb begin
        stateNext = state;
        hitLoad   = 1'b0;
        if (i_breakpointEnableN) begin
            stateNext = DISARMED;
        end else begin
            case (state)
                DISARMED: stateNext = RUN;
                RUN: begin
                    if (match) begin
                        stateNext = HIT;
                        hitLoad   = 1'b1;
                    end
                end
                HIT: begin
                    if (match) begin
                        stateNext = HIT;
                        hitLoad   = 1'b1;
                    end else if (i_continue || i_halt) begin
                        stateNext = RUN;
                    end
                end
                default: stateNext = DISARMED;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state            <= DISARMED;
            o_breakpointHitN <= 1'b1;
            o_hitIndex       <= '0;
        end else begin
            state            <= stateNext;
            o_breakpointHitN <= (stateNext != HIT);
            if (hitLoad) begin
                o_hitIndex <= matchIdx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < NumEntries; i++) begin
                bpAddr[i] <= '0;
            end
            bpValid <= '0;
        end else if (bpBus.i_bpWrite) begin
            bpAddr[bpBus.i_bpIndex]  <= bpBus.i_bpAddr;
            bpValid[bpBus.i_bpIndex] <= bpBus.i_bpValid;
        end
    end

`ifdef BREAKPOINT_COUNT_EN
    // Saturating count of hit entries, including re-entries while already halted.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_hitCount <= '0;
        end else if (hitLoad && (o_hitCount != 8'hFF)) begin
            o_hitCount <= o_hitCount + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed vector bench for breakpoint_unit: table of per-cycle stimulus with expected outputs,
// followed by hand-written reset and saturation sequences.
module tb_breakpoint_unit;
    logic        i_clk;
    logic        i_resetn;
    logic        i_breakpointEnableN;
    logic        i_halt;
    logic        i_ctrlInstrFinishedN;
    logic [15:0] i_pc;
    logic        i_continue;
    logic        o_breakpointHitN;
    logic [1:0]  o_hitIndex;
`ifdef BREAKPOINT_COUNT_EN
    logic [7:0]  o_hitCount;
`endif

    breakpoint_unit_if bpIf ();

    breakpoint_unit dut (
        .i_clk                (i_clk),
        .i_resetn             (i_resetn),
        .i_breakpointEnableN  (i_breakpointEnableN),
        .i_halt               (i_halt),
        .i_ctrlInstrFinishedN (i_ctrlInstrFinishedN),
        .i_pc                 (i_pc),
        .i_continue           (i_continue),
        .bpBus                (bpIf),
        .o_breakpointHitN     (o_breakpointHitN),
        .o_hitIndex           (o_hitIndex)
`ifdef BREAKPOINT_COUNT_EN
        ,
        .o_hitCount           (o_hitCount)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic        enN;
        logic        halt;
        logic        finN;
        logic [15:0] pc;
        logic        cont;
        logic        wr;
        logic [1:0]  idx;
        logic [15:0] addr;
        logic        valid;
        logic        expHitN;
        logic [1:0]  expIdx;
    } vec_t;

    localparam int NumVecs = 27;
    vec_t vecs [NumVecs];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic enN, input logic halt, input logic finN, input logic [15:0] pc,
                         input logic cont, input logic wr, input logic [1:0] idx,
                         input logic [15:0] addr, input logic valid);
        i_breakpointEnableN  = enN;
        i_halt               = halt;
        i_ctrlInstrFinishedN = finN;
        i_pc                 = pc;
        i_continue           = cont;
        bpIf.i_bpWrite       = wr;
        bpIf.i_bpIndex       = idx;
        bpIf.i_bpAddr        = addr;
        bpIf.i_bpValid       = valid;
    endtask

    function automatic vec_t mk(input logic enN, input logic halt, input logic finN, input logic [15:0] pc,
                                input logic cont, input logic wr, input logic [1:0] idx,
                                input logic [15:0] addr, input logic valid,
                                input logic expHitN, input logic [1:0] expIdx);
        vec_t v;
        v.enN = enN; v.halt = halt; v.finN = finN; v.pc = pc; v.cont = cont;
        v.wr = wr; v.idx = idx; v.addr = addr; v.valid = valid;
        v.expHitN = expHitN; v.expIdx = expIdx;
        return v;
    endfunction

    initial begin
        //             enN  halt finN pc        cont wr   idx  addr      v     hitN idx
        vecs[0]  = mk(1'b1,1'b1,1'b1,16'h0000,1'b0,1'b1,2'd1,16'h0040,1'b1, 1'b1,2'd0);
        vecs[1]  = mk(1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd0);
        vecs[2]  = mk(1'b0,1'b1,1'b0,16'h0040,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd1);
        vecs[3]  = mk(1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd1);
        vecs[4]  = mk(1'b0,1'b0,1'b1,16'h0000,1'b1,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd1);
        vecs[5]  = mk(1'b0,1'b1,1'b1,16'h0000,1'b0,1'b1,2'd0,16'h0100,1'b1, 1'b1,2'd1);
        vecs[6]  = mk(1'b0,1'b1,1'b1,16'h0000,1'b0,1'b1,2'd2,16'h0100,1'b1, 1'b1,2'd1);
        vecs[7]  = mk(1'b0,1'b1,1'b0,16'h0100,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd0);
        vecs[8]  = mk(1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd0);
        vecs[9]  = mk(1'b0,1'b0,1'b1,16'h0000,1'b1,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd0);
        vecs[10] = mk(1'b0,1'b1,1'b0,16'h0040,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd1);
        vecs[11] = mk(1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd1);
        vecs[12] = mk(1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd1);
        vecs[13] = mk(1'b0,1'b1,1'b0,16'h0040,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd1);
        vecs[14] = mk(1'b0,1'b1,1'b0,16'h0100,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd0);
        vecs[15] = mk(1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd0);
        vecs[16] = mk(1'b1,1'b0,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd0);
        vecs[17] = mk(1'b1,1'b1,1'b0,16'h0040,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd0);
        vecs[18] = mk(1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd0);
        vecs[19] = mk(1'b0,1'b1,1'b0,16'h0200,1'b0,1'b1,2'd3,16'h0200,1'b1, 1'b1,2'd0);
        vecs[20] = mk(1'b0,1'b1,1'b0,16'h0200,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd3);
        vecs[21] = mk(1'b0,1'b0,1'b1,16'h0000,1'b0,1'b1,2'd3,16'h0300,1'b1, 1'b0,2'd3);
        vecs[22] = mk(1'b0,1'b0,1'b1,16'h0000,1'b1,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd3);
        vecs[23] = mk(1'b0,1'b1,1'b1,16'h0000,1'b1,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd3);
        vecs[24] = mk(1'b0,1'b1,1'b0,16'h0200,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd3);
        vecs[25] = mk(1'b0,1'b0,1'b0,16'h0300,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b1,2'd3);
        vecs[26] = mk(1'b0,1'b1,1'b0,16'h0300,1'b0,1'b0,2'd0,16'h0000,1'b0, 1'b0,2'd3);

        // Reset and idle
        i_resetn = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset hitN", int'(o_breakpointHitN), 1);
        check("reset hitIndex", int'(o_hitIndex), 0);
`ifdef BREAKPOINT_COUNT_EN
        check("reset hitCount", int'(o_hitCount), 0);
`endif
        @(negedge i_clk);
        i_resetn = 1'b1;

        // Table vectors: drive, clock, sample 1ns after the edge
        for (int k = 0; k < NumVecs; k++) begin
            drive(vecs[k].enN, vecs[k].halt, vecs[k].finN, vecs[k].pc, vecs[k].cont,
                  vecs[k].wr, vecs[k].idx, vecs[k].addr, vecs[k].valid);
            @(posedge i_clk);
            #1;
            check($sformatf("vec%0d hitN", k), int'(o_breakpointHitN), int'(vecs[k].expHitN));
            check($sformatf("vec%0d hitIndex", k), int'(o_hitIndex), int'(vecs[k].expIdx));
        end
`ifdef BREAKPOINT_COUNT_EN
        check("hitCount after table", int'(o_hitCount), 7);
`endif

        // Asynchronous reset in HIT must release the halt before any edge
        check("pre-reset in HIT", int'(o_breakpointHitN), 0);
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        #2;
        i_resetn = 1'b0;
        #1;
        check("async reset hitN", int'(o_breakpointHitN), 1);
        check("async reset hitIndex", int'(o_hitIndex), 0);
`ifdef BREAKPOINT_COUNT_EN
        check("async reset hitCount", int'(o_hitCount), 0);
`endif
        #1;
        i_resetn = 1'b1;

        // First armed edge enters RUN; table was cleared so 0x0040 no longer hits
        drive(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 2'd0, 16'h0010, 1'b1);
        @(posedge i_clk);
        #1;
        check("post-reset run hitN", int'(o_breakpointHitN), 1);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        @(posedge i_clk);
        #1;
        check("cleared entry no hit", int'(o_breakpointHitN), 1);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        @(posedge i_clk);
        #1;
        check("post-reset hit hitN", int'(o_breakpointHitN), 0);
        check("post-reset hit index", int'(o_hitIndex), 0);
`ifdef BREAKPOINT_COUNT_EN
        check("hitCount first", int'(o_hitCount), 1);
`endif

        // 259 further re-entry hits, 260 total
        repeat (259) @(posedge i_clk);
        #1;
        check("re-entry hitN held", int'(o_breakpointHitN), 0);
`ifdef BREAKPOINT_COUNT_EN
        check("hitCount saturated", int'(o_hitCount), 255);
`endif
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
        @(posedge i_clk);
        #1;
        check("final continue hitN", int'(o_breakpointHitN), 1);
`ifdef BREAKPOINT_COUNT_EN
        check("hitCount stays saturated", int'(o_hitCount), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/breakpoint_unit.md
BREAKPOINT_UNIT -- requirements
Module: breakpoint_unit

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: i_resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have: i_breakpointEnableN  in  1  0 = breakpoints armed, 1 = disabled (from clock block).
REQ-004 SHALL have: i_halt  in  1  CPU run qualifier from clock block; 1 = CPU clocked this cycle, 0 = halted.
REQ-005 SHALL have: i_ctrlInstrFinishedN  in  1  0 = last microstep of current instruction.
REQ-006 SHALL have: i_pc  in  16  address of next instruction, valid when i_ctrlInstrFinishedN = 0.
REQ-007 SHALL have: i_continue  in  1  synchronous one-cycle resume request.
REQ-008 SHALL have: i_bpWrite  in  1, i_bpIndex  in  2, i_bpAddr  in  16, i_bpValid  in  1  breakpoint table write port.
REQ-009 SHALL have: o_breakpointHitN  out  1  0 = breakpoint hit, CPU must halt (to clock block).
REQ-010 SHALL have: o_hitIndex  out  2  entry that caused the last hit.
REQ-011 SHALL have (only with BREAKPOINT_COUNT_EN): o_hitCount  out  8  number of hits since reset.

Function
REQ-012 SHALL hold 4 entries, each 16-bit address plus valid bit.
REQ-013 SHALL write entry i_bpIndex with {i_bpAddr, i_bpValid} on a rising edge with i_bpWrite = 1; written value visible to comparisons from the next cycle.
REQ-014 SHALL define a boundary cycle as i_ctrlInstrFinishedN = 0 and i_halt = 1.
REQ-015 SHALL flag a match when, in a boundary cycle, i_breakpointEnableN = 0 and any valid entry address equals i_pc.
REQ-016 SHALL select the lowest-numbered matching entry when several match; o_hitIndex SHALL load it in the same edge as entering HIT and hold until the next hit.
REQ-017 SHALL implement states DISARMED, RUN, HIT; o_breakpointHitN = 0 only in HIT, registered (one-cycle latency from boundary cycle).
REQ-018 DISARMED -> RUN when i_breakpointEnableN = 0; any state -> DISARMED when i_breakpointEnableN = 1 (highest priority after reset).
REQ-019 RUN -> HIT on match.
REQ-020 HIT -> RUN on i_continue = 1 or on i_halt = 1 (CPU single-stepped past the breakpoint).
REQ-021 In HIT, a match in the same cycle as an exit condition SHALL keep the state in HIT (match wins).
REQ-022 i_continue in RUN or DISARMED SHALL be ignored.
REQ-023 A write to the entry that caused the current hit SHALL NOT clear HIT.
REQ-024 Write and boundary in the same cycle SHALL compare against the pre-write table contents.

Reset
REQ-025 On i_resetn = 0 SHALL immediately set state DISARMED, o_breakpointHitN = 1, o_hitIndex = 0, all entries invalid with address 0, o_hitCount = 0.
REQ-026 Reset asserted while in HIT SHALL release the halt asynchronously, without waiting for a clock edge.
REQ-027 After reset release, SHALL enter RUN on the first edge with i_breakpointEnableN = 0.

Configuration
REQ-028 With BREAKPOINT_COUNT_EN defined SHALL provide o_hitCount, incremented on every RUN -> HIT (or HIT re-entry per REQ-021), saturating at 255.
REQ-029 Without BREAKPOINT_COUNT_EN SHALL omit o_hitCount and its counter; all other behaviour SHALL be identical.

Verification
REQ-030 Write entry 1 = 0x0040 valid, armed, boundary with i_pc = 0x0040 -> o_breakpointHitN = 0 next cycle, o_hitIndex = 1.
REQ-031 Entries 0 and 2 both = 0x0100 valid, boundary at 0x0100 -> o_hitIndex = 0; i_continue pulse -> o_breakpointHitN = 1 next cycle.
REQ-032 Hit held, i_halt = 1 for one cycle with no boundary -> RUN, o_breakpointHitN = 1; same with boundary at matching pc -> stays 0.
REQ-033 Hit held, i_breakpointEnableN -> 1 -> o_breakpointHitN = 1 next cycle; boundary at 0x0040 while disabled -> no hit.
REQ-034 Write entry 3 = 0x0200 in same cycle as boundary at 0x0200 -> no hit; repeat boundary next cycle -> hit.
REQ-035 Reset pulse while in HIT -> o_breakpointHitN = 1 before next edge; with BREAKPOINT_COUNT_EN, 260 hits -> o_hitCount = 255.
